// File: rtl/edge_sticky_array_if.sv
// Bundle of pad-side inputs and status outputs for the edge_sticky_array block.
// The master drives channel inputs and controls; the slave returns flags, counts and irq.
interface edge_sticky_array_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       ch_in;
    logic [2*N_CH-1:0]     edge_mode;
    logic [N_CH-1:0]       clr;
    logic [N_CH-1:0]       irq_en;
    logic [N_CH-1:0]       flag;
    logic [N_CH*CNT_W-1:0] cnt;
    logic                  irq;

    modport master (
        output ch_in, edge_mode, clr, irq_en,
        input  flag, cnt, irq
    );

    modport slave (
        input  ch_in, edge_mode, clr, irq_en,
        output flag, cnt, irq
    );
endinterface

// File: rtl/edge_sticky_array.sv
// Per-channel input synchroniser, programmable edge detector, sticky flag and
// saturating event counter, with a registered masked interrupt over all flags.
module edge_sticky_array #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    edge_sticky_array_if.slave  bus
);

    logic [N_CH-1:0]       sync_r [SYNC_STAGES];
    logic [N_CH-1:0]       prev_r;
    logic [N_CH-1:0]       sync_out_s;
    logic [N_CH-1:0]       ev_s;
    logic [N_CH-1:0]       flag_r;
    logic [N_CH-1:0]       flag_nxt_s;
    logic [N_CH*CNT_W-1:0] cnt_r;
    logic [N_CH*CNT_W-1:0] cnt_nxt_s;
    logic                  irq_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1'b1);
        end
        return r;
    endfunction

    // Synchroniser chain plus the one-cycle edge-history flop behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_r[j] <= '0;
            end
            prev_r <= '0;
        end else begin
            sync_r[0] <= bus.ch_in;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_r[j] <= sync_r[j-1];
            end
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Edge qualification against the live mode; mode 00 never fires
    always_comb begin
        sync_out_s = sync_r[SYNC_STAGES-1];
        ev_s       = '0;
        for (int i = 0; i < N_CH; i++) begin
            ev_s[i] = (bus.edge_mode[2*i]   &  sync_out_s[i] & ~prev_r[i]) |
                      (bus.edge_mode[2*i+1] & ~sync_out_s[i] &  prev_r[i]);
        end
    end

    // Next flag/count: an event always beats a simultaneous clear
    always_comb begin
        flag_nxt_s = flag_r;
        cnt_nxt_s  = cnt_r;
        for (int i = 0; i < N_CH; i++) begin
            if (ev_s[i]) begin
                flag_nxt_s[i] = 1'b1;
            end else if (bus.clr[i]) begin
                flag_nxt_s[i] = 1'b0;
            end else begin
                flag_nxt_s[i] = flag_r[i];
            end

            if (bus.clr[i]) begin
                cnt_nxt_s[i*CNT_W +: CNT_W] = ev_s[i] ? CNT_W'(1'b1) : CNT_W'(1'b0);
            end else if (ev_s[i]) begin
                cnt_nxt_s[i*CNT_W +: CNT_W] = sat_inc(cnt_r[i*CNT_W +: CNT_W]);
            end else begin
                cnt_nxt_s[i*CNT_W +: CNT_W] = cnt_r[i*CNT_W +: CNT_W];
            end
        end
    end

    // Status registers; irq looks at the flag register, so it trails flag by a cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_r <= '0;
            cnt_r  <= '0;
            irq_r  <= 1'b0;
        end else begin
            flag_r <= flag_nxt_s;
            cnt_r  <= cnt_nxt_s;
            irq_r  <= |(flag_r & bus.irq_en);
        end
    end

    assign bus.flag = flag_r;
    assign bus.cnt  = cnt_r;
    assign bus.irq  = irq_r;

endmodule

// File: tb/tb_edge_sticky_array.sv
// Self-checking bench for edge_sticky_array: directed scenarios plus a randomized
// run compared against a sample-history reference model.
module tb_edge_sticky_array;

    localparam int N_CH        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 3;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    edge_sticky_array_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus();

    edge_sticky_array #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: ch_in samples per edge, flags, counts, irq
    logic [N_CH-1:0] hist_q[$];
    logic [N_CH-1:0] m_flag;
    int              m_cnt [N_CH];
    logic            m_irq;

    task automatic model_clear();
        m_flag = '0;
        m_irq  = 1'b0;
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        hist_q.delete();
        for (int j = 0; j <= SYNC_STAGES; j++) hist_q.push_back('0);
    endtask

    // The detector at edge t sees the inputs sampled SYNC_STAGES and SYNC_STAGES+1 edges earlier
    task automatic model_step();
        logic [N_CH-1:0] cur;
        logic [N_CH-1:0] old;
        logic            nirq;
        logic            e;
        cur  = hist_q[SYNC_STAGES-1];
        old  = hist_q[SYNC_STAGES];
        nirq = |(m_flag & bus.irq_en);
        for (int i = 0; i < N_CH; i++) begin
            e = (bus.edge_mode[2*i] && cur[i] && !old[i]) ||
                (bus.edge_mode[2*i+1] && !cur[i] && old[i]);
            if (bus.clr[i]) m_cnt[i] = e ? 1 : 0;
            else if (e) m_cnt[i] = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
            if (e) m_flag[i] = 1'b1;
            else if (bus.clr[i]) m_flag[i] = 1'b0;
        end
        m_irq = nirq;
        hist_q.push_front(bus.ch_in);
        void'(hist_q.pop_back());
    endtask

    function automatic logic [N_CH*CNT_W-1:0] model_cnt_vec();
        logic [N_CH*CNT_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] dut_cnt(input int i);
        return bus.cnt[i*CNT_W +: CNT_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.ch_in     = '0;
        bus.edge_mode = '0;
        bus.clr       = '0;
        bus.irq_en    = '0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.flag !== 4'b0000) begin bad++; $display("FAIL reset_flag: got %b expected %b", bus.flag, 4'b0000); end
        total++; if (bus.cnt !== 12'h000) begin bad++; $display("FAIL reset_cnt: got %h expected %h", bus.cnt, 12'h000); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected %b", bus.irq, 1'b0); end
    endtask

    task automatic test_rise_detect();
        do_reset();
        bus.edge_mode = 8'b0000_0001;
        bus.irq_en    = 4'b0001;
        bus.ch_in[0]  = 1'b1;
        tick();
        tick();
        total++; if (bus.flag !== 4'b0000) begin bad++; $display("FAIL rise_early: got %b expected %b", bus.flag, 4'b0000); end
        tick();
        total++; if (bus.flag !== 4'b0001) begin bad++; $display("FAIL rise_flag: got %b expected %b", bus.flag, 4'b0001); end
        total++; if (bus.cnt !== 12'h001) begin bad++; $display("FAIL rise_cnt: got %h expected %h", bus.cnt, 12'h001); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL rise_irq_early: got %b expected %b", bus.irq, 1'b0); end
        tick();
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL rise_irq: got %b expected %b", bus.irq, 1'b1); end
    endtask

    task automatic test_both_saturate();
        int exp_c;
        do_reset();
        bus.edge_mode = 8'b0000_1100;
        for (int t = 0; t < 10; t++) begin
            bus.ch_in[1] = ~bus.ch_in[1];
            repeat (4) tick();
            exp_c = (t + 1 > CNT_MAX) ? CNT_MAX : t + 1;
            total++; if (dut_cnt(1) !== CNT_W'(exp_c)) begin bad++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", t, dut_cnt(1), exp_c); end
            total++; if (bus.flag[1] !== 1'b1) begin bad++; $display("FAIL sat_flag[%0d]: got %b expected %b", t, bus.flag[1], 1'b1); end
        end
    endtask

    task automatic test_set_over_clear();
        do_reset();
        bus.edge_mode = 8'b0001_0000;
        for (int p = 0; p < 5; p++) begin
            bus.ch_in[2] = 1'b1;
            repeat (3) tick();
            bus.ch_in[2] = 1'b0;
            repeat (3) tick();
        end
        total++; if (dut_cnt(2) !== 3'd5) begin bad++; $display("FAIL coll_pre_cnt: got %0d expected %0d", dut_cnt(2), 5); end
        bus.ch_in[2] = 1'b1;
        tick();
        tick();
        bus.clr[2] = 1'b1;
        tick();
        bus.clr[2] = 1'b0;
        total++; if (bus.flag[2] !== 1'b1) begin bad++; $display("FAIL coll_flag: got %b expected %b", bus.flag[2], 1'b1); end
        total++; if (dut_cnt(2) !== 3'd1) begin bad++; $display("FAIL coll_cnt: got %0d expected %0d", dut_cnt(2), 1); end
        bus.clr[2] = 1'b1;
        tick();
        bus.clr[2] = 1'b0;
        total++; if (bus.flag[2] !== 1'b0) begin bad++; $display("FAIL clr_flag: got %b expected %b", bus.flag[2], 1'b0); end
        total++; if (dut_cnt(2) !== 3'd0) begin bad++; $display("FAIL clr_cnt: got %0d expected %0d", dut_cnt(2), 0); end
    endtask

    task automatic test_mode_off_falling();
        do_reset();
        bus.ch_in[3] = 1'b1;
        repeat (3) tick();
        bus.ch_in[3] = 1'b0;
        repeat (4) tick();
        total++; if (bus.flag[3] !== 1'b0) begin bad++; $display("FAIL off_flag: got %b expected %b", bus.flag[3], 1'b0); end
        bus.edge_mode = 8'b1000_0000;
        bus.ch_in[3]  = 1'b1;
        repeat (4) tick();
        total++; if (dut_cnt(3) !== 3'd0) begin bad++; $display("FAIL fall_on_rise: got %0d expected %0d", dut_cnt(3), 0); end
        bus.ch_in[3] = 1'b0;
        tick();
        tick();
        total++; if (dut_cnt(3) !== 3'd0) begin bad++; $display("FAIL fall_early: got %0d expected %0d", dut_cnt(3), 0); end
        tick();
        total++; if (dut_cnt(3) !== 3'd1) begin bad++; $display("FAIL fall_cnt: got %0d expected %0d", dut_cnt(3), 1); end
        total++; if (bus.flag[3] !== 1'b1) begin bad++; $display("FAIL fall_flag: got %b expected %b", bus.flag[3], 1'b1); end
        repeat (3) tick();
        total++; if (dut_cnt(3) !== 3'd1) begin bad++; $display("FAIL fall_once: got %0d expected %0d", dut_cnt(3), 1); end
    endtask

    task automatic test_masking();
        do_reset();
        bus.edge_mode = 8'b0001_0001;
        bus.ch_in     = 4'b0101;
        repeat (4) tick();
        bus.irq_en = 4'b1010;
        repeat (2) tick();
        total++; if (bus.flag !== 4'b0101) begin bad++; $display("FAIL mask_flag: got %b expected %b", bus.flag, 4'b0101); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL mask_irq0: got %b expected %b", bus.irq, 1'b0); end
        bus.irq_en = 4'b0001;
        tick();
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL mask_irq1: got %b expected %b", bus.irq, 1'b1); end
        total++; if (bus.flag !== 4'b0101) begin bad++; $display("FAIL mask_flag_hold: got %b expected %b", bus.flag, 4'b0101); end
        bus.irq_en = 4'b0000;
        tick();
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL mask_drop: got %b expected %b", bus.irq, 1'b0); end
        total++; if (bus.flag !== 4'b0101) begin bad++; $display("FAIL mask_flag_keep: got %b expected %b", bus.flag, 4'b0101); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.edge_mode = 8'b0000_0011;
        bus.irq_en    = 4'b0001;
        bus.ch_in[0] = 1'b1; repeat (3) tick();
        bus.ch_in[0] = 1'b0; repeat (3) tick();
        bus.ch_in[0] = 1'b1; repeat (3) tick();
        total++; if (dut_cnt(0) !== 3'd3) begin bad++; $display("FAIL ar_pre_cnt: got %0d expected %0d", dut_cnt(0), 3); end
        total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL ar_pre_irq: got %b expected %b", bus.irq, 1'b1); end
        bus.ch_in[0] = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.flag !== 4'b0000) begin bad++; $display("FAIL ar_flag: got %b expected %b", bus.flag, 4'b0000); end
        total++; if (bus.cnt !== 12'h000) begin bad++; $display("FAIL ar_cnt: got %h expected %h", bus.cnt, 12'h000); end
        total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL ar_irq: got %b expected %b", bus.irq, 1'b0); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();
        total++; if (bus.flag !== 4'b0000) begin bad++; $display("FAIL ar_post_flag: got %b expected %b", bus.flag, 4'b0000); end
        total++; if (bus.cnt !== 12'h000) begin bad++; $display("FAIL ar_post_cnt: got %h expected %h", bus.cnt, 12'h000); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 3) == 0) bus.ch_in[i] = ~bus.ch_in[i];
                bus.clr[i] = ($urandom_range(0, 11) == 0);
            end
            if ($urandom_range(0, 15) == 0) bus.edge_mode = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bus.irq_en = 4'($urandom);
            tick();
            total++; if (bus.flag !== m_flag) begin bad++; $display("FAIL rand_flag@%0d: got %b expected %b", n, bus.flag, m_flag); end
            total++; if (bus.cnt !== model_cnt_vec()) begin bad++; $display("FAIL rand_cnt@%0d: got %h expected %h", n, bus.cnt, model_cnt_vec()); end
            total++; if (bus.irq !== m_irq) begin bad++; $display("FAIL rand_irq@%0d: got %b expected %b", n, bus.irq, m_irq); end
        end
        bus.clr = '0;
    endtask

    initial begin
        bus.ch_in     = '0;
        bus.edge_mode = '0;
        bus.clr       = '0;
        bus.irq_en    = '0;
        model_clear();
        test_reset();
        test_rise_detect();
        test_both_saturate();
        test_set_over_clear();
        test_mode_off_falling();
        test_masking();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
